// File: rtl/float_pkg.sv
// Shared definitions for the parametrised floating-point multiply unit:
// format helpers, operand classes, special-result kinds and flag indices.
package float_pkg;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fclass_t;

    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    localparam int unsigned MUL_LATENCY    = 3;
    localparam int unsigned NUM_FLAGS      = 3;
    localparam int unsigned FLAG_UNDERFLOW = 0;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_INVALID   = 2;
    localparam int unsigned MAX_FW         = 128;

    function automatic int unsigned float_width(input int unsigned ew, input int unsigned mw);
        return 1 + ew + mw;
    endfunction

    function automatic int unsigned float_bias(input int unsigned ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN {0, all-ones exponent, 1 then zeros}, right-aligned in MAX_FW bits.
    function automatic logic [MAX_FW-1:0] canonical_qnan(input int unsigned ew, input int unsigned mw);
        logic [MAX_FW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < ew; i++) begin
            v[mw + i] = 1'b1;
        end
        v[mw - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/float_mul_norm_round.sv
// Combinational final stage of the multiplier: normalise the raw mantissa
// product, round, detect overflow/underflow and pack the result with flags.
module float_mul_norm_round
    import float_pkg::*;
#(
    parameter  int unsigned EXP_WIDTH  = 8,
    parameter  int unsigned MANT_WIDTH = 23,
    localparam int unsigned FW         = float_width(EXP_WIDTH, MANT_WIDTH),
    localparam int unsigned EW         = EXP_WIDTH + 2,
    localparam int unsigned PW         = 2 * MANT_WIDTH + 2
) (
    input  logic                 sign,
    input  logic signed [EW-1:0] exp_sum,
    input  logic [PW-1:0]        prod,
    input  special_t             special,
    input  logic                 round_mode,
    output logic [FW-1:0]        res,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam logic [MAX_FW-1:0]    QNAN   = canonical_qnan(EXP_WIDTH, MANT_WIDTH);
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = '0;
    localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_WIDTH) - 1);

    logic [PW-2:0]          norm;
    logic signed [EW-1:0]   exp_norm;
    logic signed [EW-1:0]   exp_rnd;
    logic [MANT_WIDTH-1:0]  mant;
    logic [MANT_WIDTH:0]    mant_rnd;
    logic                   guard;
    logic                   sticky;
    logic                   inc;

    // norm drops the hidden bit: its top MANT_WIDTH bits are the stored mantissa.
    always_comb begin
        norm     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        exp_norm = prod[PW-1] ? exp_sum + ONE : exp_sum;
        mant     = norm[PW-2 -: MANT_WIDTH];
        guard    = norm[MANT_WIDTH];
        sticky   = |norm[MANT_WIDTH-1:0];
        inc      = round_mode & guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, inc};
        exp_rnd  = mant_rnd[MANT_WIDTH] ? exp_norm + ONE : exp_norm;
    end

    always_comb begin
        res   = '0;
        flags = '0;
        unique case (special)
            SP_NAN: begin
                res                 = QNAN[FW-1:0];
                flags[FLAG_INVALID] = 1'b1;
            end
            SP_INF:  res = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            SP_ZERO: res = {sign, {(FW-1){1'b0}}};
            default: begin
                if (exp_rnd >= EMAX) begin
                    res                  = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    flags[FLAG_OVERFLOW] = 1'b1;
                end else if (exp_rnd <= ZERO_E) begin
                    res                   = {sign, {(FW-1){1'b0}}};
                    flags[FLAG_UNDERFLOW] = 1'b1;
                end else begin
                    res = {sign, exp_rnd[EXP_WIDTH-1:0], mant_rnd[MANT_WIDTH-1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/float_mul_pipeline_param.sv
// Shared pipelined FP multiplier: one op per cycle, tag passthrough,
// output backpressure stalling the whole pipe, RNE/truncate rounding.
module float_mul_pipeline_param
    import float_pkg::*;
#(
    parameter  int unsigned EXP_WIDTH  = 8,
    parameter  int unsigned MANT_WIDTH = 23,
    parameter  int unsigned TAG_WIDTH  = 4,
    localparam int unsigned FW         = float_width(EXP_WIDTH, MANT_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    output logic                 in_ready,
    input  logic [FW-1:0]        a,
    input  logic [FW-1:0]        b,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 round_mode,
    output logic                 ack,
    input  logic                 out_ready,
    output logic [FW-1:0]        out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int unsigned          EW   = EXP_WIDTH + 2;
    localparam int unsigned          MW   = MANT_WIDTH + 1;
    localparam int unsigned          PW   = 2 * MW;
    localparam logic signed [EW-1:0] BIAS = EW'(float_bias(EXP_WIDTH));

    logic                  adv;

    logic                  s0_valid;
    logic [FW-1:0]         s0_a;
    logic [FW-1:0]         s0_b;
    logic [TAG_WIDTH-1:0]  s0_tag;
    logic                  s0_rm;

    logic                  s1_valid;
    logic                  s1_sign;
    logic signed [EW-1:0]  s1_exp;
    logic [MW-1:0]         s1_ma;
    logic [MW-1:0]         s1_mb;
    special_t              s1_special;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic                  s1_rm;

    logic                  s2_valid;
    logic                  s2_sign;
    logic signed [EW-1:0]  s2_exp;
    logic [PW-1:0]         s2_prod;
    special_t              s2_special;
    logic [TAG_WIDTH-1:0]  s2_tag;
    logic                  s2_rm;

    logic [EXP_WIDTH-1:0]  ea;
    logic [EXP_WIDTH-1:0]  eb;
    logic [MANT_WIDTH-1:0] ma;
    logic [MANT_WIDTH-1:0] mb;
    fclass_t               cls_a;
    fclass_t               cls_b;
    special_t              special_c;
    logic signed [EW-1:0]  exp_c;
    logic [FW-1:0]         res;
    logic [NUM_FLAGS-1:0]  res_flags;

    function automatic fclass_t classify(input logic [EXP_WIDTH-1:0] e, input logic [MANT_WIDTH-1:0] m);
        if (e == '0) return ZERO;
        if (&e) return (m == '0) ? INF : NAN;
        return NORMAL;
    endfunction

    assign adv      = ~ack | out_ready;
    assign in_ready = adv;

    // Denormal inputs classify as ZERO, so they are flushed by the special path.
    always_comb begin
        ea    = s0_a[FW-2 -: EXP_WIDTH];
        eb    = s0_b[FW-2 -: EXP_WIDTH];
        ma    = s0_a[MANT_WIDTH-1:0];
        mb    = s0_b[MANT_WIDTH-1:0];
        cls_a = classify(ea, ma);
        cls_b = classify(eb, mb);
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
            special_c = SP_NAN;
        else if (cls_a == INF || cls_b == INF)
            special_c = SP_INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            special_c = SP_ZERO;
        else
            special_c = SP_NONE;
        exp_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    float_mul_norm_round #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_norm_round (
        .sign       (s2_sign),
        .exp_sum    (s2_exp),
        .prod       (s2_prod),
        .special    (s2_special),
        .round_mode (s2_rm),
        .res        (res),
        .flags      (res_flags)
    );

    // Operands are registered on acceptance, so the unpack logic is off the issue path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_valid   <= 1'b0;
            s0_a       <= '0;
            s0_b       <= '0;
            s0_tag     <= '0;
            s0_rm      <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_ma      <= '0;
            s1_mb      <= '0;
            s1_special <= SP_NONE;
            s1_tag     <= '0;
            s1_rm      <= 1'b0;
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_prod    <= '0;
            s2_special <= SP_NONE;
            s2_tag     <= '0;
            s2_rm      <= 1'b0;
            ack        <= 1'b0;
            out        <= '0;
            tag_out    <= '0;
            flags      <= '0;
        end else if (adv) begin
            s0_valid   <= req;
            s0_a       <= a;
            s0_b       <= b;
            s0_tag     <= tag_in;
            s0_rm      <= round_mode;

            s1_valid   <= s0_valid;
            s1_sign    <= s0_a[FW-1] ^ s0_b[FW-1];
            s1_exp     <= exp_c;
            s1_ma      <= {1'b1, ma};
            s1_mb      <= {1'b1, mb};
            s1_special <= special_c;
            s1_tag     <= s0_tag;
            s1_rm      <= s0_rm;

            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_exp     <= s1_exp;
            s2_prod    <= PW'(s1_ma) * PW'(s1_mb);
            s2_special <= s1_special;
            s2_tag     <= s1_tag;
            s2_rm      <= s1_rm;

            ack        <= s2_valid;
            out        <= s2_valid ? res : '0;
            tag_out    <= s2_valid ? s2_tag : '0;
            flags      <= s2_valid ? res_flags : '0;
        end
    end

endmodule

// File: tb/tb_float_mul_pipeline_param.sv
// Directed bench for float_mul_pipeline_param: fp32 scoreboard with latency,
// rounding, exceptions, streaming under backpressure, async reset; fp16 instance.
module tb_float_mul_pipeline_param;

    logic        clk;
    logic        rst;
    logic        req;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag_in;
    logic        round_mode;
    logic        ack;
    logic        out_ready;
    logic [31:0] out;
    logic [3:0]  tag_out;
    logic [2:0]  flags;

    logic        req16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [3:0]  tag_in16;
    logic        ack16;
    logic [15:0] out16;
    logic [3:0]  tag_out16;
    logic [2:0]  flags16;

    typedef struct {
        logic [31:0] out;
        logic [3:0]  tag;
        logic [2:0]  flags;
        int          acc_edge;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int   vectors     = 0;
    int   miscompares = 0;
    int   popped      = 0;
    int   edge_n      = 0;
    logic smp_ack;
    logic smp_in_ready;

    logic [31:0] fval [0:7] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] pval [0:7] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                                32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    float_mul_pipeline_param dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .tag_in     (tag_in),
        .round_mode (round_mode),
        .ack        (ack),
        .out_ready  (out_ready),
        .out        (out),
        .tag_out    (tag_out),
        .flags      (flags)
    );

    float_mul_pipeline_param #(
        .EXP_WIDTH  (5),
        .MANT_WIDTH (10),
        .TAG_WIDTH  (4)
    ) dut16 (
        .clk        (clk),
        .rst        (rst),
        .req        (req16),
        .in_ready   (in_ready16),
        .a          (a16),
        .b          (b16),
        .tag_in     (tag_in16),
        .round_mode (1'b1),
        .ack        (ack16),
        .out_ready  (1'b1),
        .out        (out16),
        .tag_out    (tag_out16),
        .flags      (flags16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Entered at posedge+1: samples at the falling edge, then crosses one rising edge.
    task automatic tick(output bit accepted);
        exp_t e;
        #4;
        smp_ack      = ack;
        smp_in_ready = in_ready;
        accepted     = req && in_ready;
        if (accepted) begin
            e          = cur;
            e.acc_edge = edge_n + 1;
            sb.push_back(e);
        end
        if (ack && out_ready) begin
            popped++;
            check("result_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out", out, e.out);
                check("tag_out", {28'b0, tag_out}, {28'b0, e.tag});
                check("flags", {29'b0, flags}, {29'b0, e.flags});
                if (e.chk_lat) check("latency", 32'(edge_n - e.acc_edge), 32'd3);
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic rm,
                         input logic [3:0] t, input logic [31:0] eo, input logic [2:0] ef,
                         input bit lat);
        bit acc;
        int n;
        a = ia; b = ib; round_mode = rm; tag_in = t; req = 1'b1;
        cur.out = eo; cur.tag = t; cur.flags = ef; cur.acc_edge = 0; cur.chk_lat = lat;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        req = 1'b0;
        check("accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick(acc);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic op16(input string name, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] eo, input logic [2:0] ef);
        int n;
        check({name, "_in_ready"}, {31'b0, in_ready16}, 32'd1);
        a16 = ia; b16 = ib; tag_in16 = 4'h5; req16 = 1'b1;
        @(posedge clk);
        #1;
        req16 = 1'b0;
        n = 0;
        while (!ack16 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_ack"}, {31'b0, ack16}, 32'd1);
        check({name, "_latency"}, 32'(n), 32'd3);
        check({name, "_out"}, {16'b0, out16}, {16'b0, eo});
        check({name, "_flags"}, {29'b0, flags16}, {29'b0, ef});
        check({name, "_tag"}, {28'b0, tag_out16}, 32'h5);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int p0;
        int sent;

        rst = 1'b1; req = 1'b0; a = '0; b = '0; tag_in = '0; round_mode = 1'b1; out_ready = 1'b1;
        req16 = 1'b0; a16 = '0; b16 = '0; tag_in16 = '0;
        #1 rst = 1'b0;
        #7;
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_tag", {28'b0, tag_out}, 32'd0);
        check("rst_flags", {29'b0, flags}, 32'd0);
        #4 rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
        check("idle_ack", {31'b0, ack}, 32'd0);

        // basic product with latency check
        issue(32'h3FC00000, 32'h40000000, 1'b1, 4'd1, 32'h40400000, 3'b000, 1'b1);
        drain();

        // rounding modes
        issue(32'h3F800001, 32'h3FC00000, 1'b1, 4'd2, 32'h3FC00002, 3'b000, 1'b1);
        issue(32'h3F800001, 32'h3FC00000, 1'b0, 4'd3, 32'h3FC00001, 3'b000, 1'b1);
        drain();

        // exceptions, issued back to back
        issue(32'h7F000000, 32'h40000000, 1'b1, 4'd4, 32'h7F800000, 3'b010, 1'b1);
        issue(32'h00800000, 32'h3F000000, 1'b1, 4'd5, 32'h00000000, 3'b001, 1'b1);
        issue(32'h7F800000, 32'h00000000, 1'b1, 4'd6, 32'h7FC00000, 3'b100, 1'b1);
        issue(32'hC0000000, 32'h00000000, 1'b1, 4'd7, 32'h80000000, 3'b000, 1'b1);
        drain();

        // streaming with a two-cycle output stall
        p0   = popped;
        sent = 0;
        for (int t = 0; t < 30; t++) begin
            out_ready = !(t == 5 || t == 6);
            if (sent < 8) begin
                a = fval[sent]; b = 32'h40000000; tag_in = 4'(sent); round_mode = 1'b1; req = 1'b1;
                cur.out = pval[sent]; cur.tag = 4'(sent); cur.flags = 3'b000;
                cur.acc_edge = 0; cur.chk_lat = 1'b0;
            end else begin
                req = 1'b0;
            end
            tick(acc);
            if (acc) sent++;
            if (t == 5 || t == 6) begin
                check("stall_ack", {31'b0, smp_ack}, 32'd1);
                check("stall_in_ready", {31'b0, smp_in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        req = 1'b0;
        check("stream_sent", 32'(sent), 32'd8);
        check("stream_results", 32'(popped - p0), 32'd8);
        drain();

        // asynchronous reset with ops in flight and a stalled result at the output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(32'h3FC00000, 32'h40000000, 1'b1, 4'(i + 8), 32'h40400000, 3'b000, 1'b0);
        end
        check("pre_rst_ack", {31'b0, ack}, 32'd1);
        check("pre_rst_out", out, 32'h40400000);
        #2 rst = 1'b0;
        #1;
        check("midrst_ack", {31'b0, ack}, 32'd0);
        check("midrst_out", out, 32'd0);
        check("midrst_tag", {28'b0, tag_out}, 32'd0);
        check("midrst_flags", {29'b0, flags}, 32'd0);
        sb.delete();
        #1 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        edge_n++;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            check("post_rst_no_ack", {31'b0, smp_ack}, 32'd0);
        end
        issue(32'h3FC00000, 32'h40000000, 1'b1, 4'd15, 32'h40400000, 3'b000, 1'b1);
        drain();

        // fp16 instance
        op16("fp16_mul", 16'h3C00, 16'h4000, 16'h4000, 3'b000);
        op16("fp16_ovf", 16'h7BFF, 16'h4000, 16'h7C00, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
